// File: rtl/bist_seq_ctrl.sv
// BIST sequencing controller: clear, pattern run, latency flush and signature
// compare for the radix-4 multiplier self-test, with start/done handshake.
module bist_seq_ctrl #(
    parameter int unsigned      PATTERNS = 256,
    parameter int unsigned      CUT_LAT  = 1,
    parameter int unsigned      SIG_W    = 8,
    parameter logic [SIG_W-1:0] GOLDEN   = SIG_W'(8'hDE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [SIG_W-1:0] sig_in,
    output logic             tpg_en,
    output logic             test_mode,
    output logic             cut_clr,
    output logic             ora_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [31:0]      result_word,
    output logic [15:0]      pat_count
);

    localparam int unsigned PAT_W = 16;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned RES_W = 32;

    localparam logic [PAT_W-1:0] PAT_LAST   = PAT_W'(PATTERNS - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'((CUT_LAT == 0) ? 0 : (CUT_LAT - 1));
    localparam logic [RES_W-1:0] WORD_PASS  = 32'h5041_5353;
    localparam logic [RES_W-1:0] WORD_FAIL  = 32'h4641_494C;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_FLUSH,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_armed;
    logic               w_armed_nxt;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic [CNT_W-1:0]   w_flush_nxt;
    logic               r_tpg_en;
    logic               r_test_mode;
    logic               r_cut_clr;
    logic               r_ora_en;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [RES_W-1:0]   r_result_word;
    logic [PAT_W-1:0]   r_pat_count;
    logic               w_tpg_nxt;
    logic               w_mode_nxt;
    logic               w_clr_nxt;
    logic               w_ora_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_pass_nxt;
    logic [RES_W-1:0]   w_word_nxt;
    logic [PAT_W-1:0]   w_pat_nxt;
    logic               w_launch;
    logic               w_abort_run;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_armed       <= 1'b1;
            r_flush_cnt   <= '0;
            r_tpg_en      <= 1'b0;
            r_test_mode   <= 1'b0;
            r_cut_clr     <= 1'b0;
            r_ora_en      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_result_word <= '0;
            r_pat_count   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_armed       <= w_armed_nxt;
            r_flush_cnt   <= w_flush_nxt;
            r_tpg_en      <= w_tpg_nxt;
            r_test_mode   <= w_mode_nxt;
            r_cut_clr     <= w_clr_nxt;
            r_ora_en      <= w_ora_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_pass        <= w_pass_nxt;
            r_result_word <= w_word_nxt;
            r_pat_count   <= w_pat_nxt;
        end
    end

    // Next state, then output values decoded from the state being entered
    always_comb begin
        w_state_nxt = r_state;
        w_armed_nxt = r_armed;
        w_flush_nxt = r_flush_cnt;
        w_tpg_nxt   = 1'b0;
        w_mode_nxt  = 1'b0;
        w_clr_nxt   = 1'b0;
        w_ora_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        w_word_nxt  = r_result_word;
        w_pat_nxt   = r_pat_count;

        // abort blocks a launch even in IDLE/DONE where it is otherwise ignored
        w_launch    = start && r_armed && !abort;
        w_abort_run = abort && (r_state inside {S_CLEAR, S_RUN, S_FLUSH, S_COMPARE});

        if (!start) begin
            w_armed_nxt = 1'b1;
        end

        case (r_state)
            S_IDLE:    if (w_launch) w_state_nxt = S_CLEAR;
            S_CLEAR:   w_state_nxt = S_RUN;
            S_RUN: begin
                if (r_pat_count == PAT_LAST) begin
                    w_state_nxt = (CUT_LAT == 0) ? S_COMPARE : S_FLUSH;
                end
            end
            S_FLUSH:   if (r_flush_cnt == FLUSH_LAST) w_state_nxt = S_COMPARE;
            S_COMPARE: begin
                w_state_nxt = S_DONE;
                w_armed_nxt = 1'b0;
            end
            S_DONE:    if (w_launch) w_state_nxt = S_CLEAR;
            default:   w_state_nxt = S_IDLE;
        endcase

        if (w_abort_run) begin
            w_state_nxt = S_IDLE;
            w_armed_nxt = 1'b0;
        end

        case (w_state_nxt)
            S_CLEAR: begin
                w_clr_nxt   = 1'b1;
                w_mode_nxt  = 1'b1;
                w_busy_nxt  = 1'b1;
                w_pat_nxt   = '0;
                w_flush_nxt = '0;
                w_done_nxt  = 1'b0;
                w_pass_nxt  = 1'b0;
                w_word_nxt  = '0;
            end
            S_RUN: begin
                w_tpg_nxt  = 1'b1;
                w_ora_nxt  = 1'b1;
                w_mode_nxt = 1'b1;
                w_busy_nxt = 1'b1;
                if (r_state == S_RUN && r_pat_count != PAT_LAST) begin
                    w_pat_nxt = r_pat_count + PAT_W'(1);
                end
            end
            S_FLUSH: begin
                w_ora_nxt   = 1'b1;
                w_mode_nxt  = 1'b1;
                w_busy_nxt  = 1'b1;
                w_flush_nxt = (r_state == S_FLUSH) ? (r_flush_cnt + CNT_W'(1)) : '0;
            end
            S_COMPARE: begin
                w_mode_nxt = 1'b1;
                w_busy_nxt = 1'b1;
            end
            S_DONE: begin
                w_done_nxt = 1'b1;
                if (r_state == S_COMPARE) begin
                    w_pass_nxt = (sig_in == GOLDEN);
                    w_word_nxt = (sig_in == GOLDEN) ? WORD_PASS : WORD_FAIL;
                end
            end
            default: begin
                w_done_nxt = 1'b0;
                w_pass_nxt = 1'b0;
                w_word_nxt = '0;
            end
        endcase
    end

    assign tpg_en      = r_tpg_en;
    assign test_mode   = r_test_mode;
    assign cut_clr     = r_cut_clr;
    assign ora_en      = r_ora_en;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign result_word = r_result_word;
    assign pat_count   = r_pat_count;

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Bench for bist_seq_ctrl: default build plus a PATTERNS=4/CUT_LAT=0 build,
// compared cycle by cycle against a timeline model of one BIST run.
module tb_bist_seq_ctrl;

    localparam int          MP     = 256;
    localparam int          ML     = 1;
    localparam int          SP     = 4;
    localparam int          SL     = 0;
    localparam logic [7:0]  GOLD   = 8'hDE;
    localparam logic [31:0] W_PASS = 32'h5041_5353;
    localparam logic [31:0] W_FAIL = 32'h4641_494C;

    typedef struct packed {
        logic        tpg;
        logic        tm;
        logic        clr;
        logic        ora;
        logic        busy;
        logic        done;
        logic        pass;
        logic [31:0] word;
        logic [15:0] pc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic start, abort;
    logic [7:0] sig_in;
    logic s_start, s_abort;
    logic [7:0] s_sig_in;

    logic m_tpg, m_tm, m_clr, m_ora, m_busy, m_done, m_pass;
    logic [31:0] m_word;
    logic [15:0] m_pc;
    logic s_tpg, s_tm, s_clr, s_ora, s_busy, s_done, s_pass;
    logic [31:0] s_word;
    logic [15:0] s_pc;

    int vectors = 0;
    int miscompares = 0;

    bist_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sig_in(sig_in),
        .tpg_en(m_tpg), .test_mode(m_tm), .cut_clr(m_clr), .ora_en(m_ora),
        .busy(m_busy), .done(m_done), .pass(m_pass),
        .result_word(m_word), .pat_count(m_pc)
    );

    bist_seq_ctrl #(.PATTERNS(SP), .CUT_LAT(SL)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort), .sig_in(s_sig_in),
        .tpg_en(s_tpg), .test_mode(s_tm), .cut_clr(s_clr), .ora_en(s_ora),
        .busy(s_busy), .done(s_done), .pass(s_pass),
        .result_word(s_word), .pat_count(s_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs j edges after the edge that sampled start
    function automatic exp_t model(input int j, input int p, input int l, input logic [7:0] sig);
        exp_t e;
        e = '0;
        if (j == 0) begin
            e.clr = 1'b1; e.tm = 1'b1; e.busy = 1'b1;
        end else if (j <= p) begin
            e.tpg = 1'b1; e.tm = 1'b1; e.ora = 1'b1; e.busy = 1'b1; e.pc = 16'(j - 1);
        end else if (j <= p + l) begin
            e.tm = 1'b1; e.ora = 1'b1; e.busy = 1'b1; e.pc = 16'(p - 1);
        end else if (j == p + l + 1) begin
            e.tm = 1'b1; e.busy = 1'b1; e.pc = 16'(p - 1);
        end else begin
            e.done = 1'b1; e.pass = (sig == GOLD);
            e.word = (sig == GOLD) ? W_PASS : W_FAIL; e.pc = 16'(p - 1);
        end
        return e;
    endfunction

    function automatic exp_t obs_m();
        exp_t o;
        o = {m_tpg, m_tm, m_clr, m_ora, m_busy, m_done, m_pass, m_word, m_pc};
        return o;
    endfunction

    function automatic exp_t obs_s();
        exp_t o;
        o = {s_tpg, s_tm, s_clr, s_ora, s_busy, s_done, s_pass, s_word, s_pc};
        return o;
    endfunction

    function automatic logic [7:0] rnd_bad();
        logic [7:0] v;
        v = 8'($urandom);
        if (v == GOLD) v = 8'h21;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t o;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        o = obs_m(); vectors++;
        if (o !== exp_t'(0)) begin miscompares++; $display("FAIL reset_main got %h exp 0", o); end
        o = obs_s(); vectors++;
        if (o !== exp_t'(0)) begin miscompares++; $display("FAIL reset_small got %h exp 0", o); end
        tick(); tick();
        o = obs_m(); vectors++;
        if (o !== exp_t'(0)) begin miscompares++; $display("FAIL reset_held got %h exp 0", o); end
        #2 rst_n = 1'b1;
        tick();
    endtask

    // Pulsed start, golden and faulty signatures, latency and pulse widths
    task automatic test_run();
        exp_t o, e;
        logic [7:0] sv;
        int clr_n, tpg_n, done_at;
        for (int r = 0; r < 3; r++) begin
            sv = (r == 0) ? GOLD : ((r == 1) ? 8'h21 : rnd_bad());
            clr_n = 0; tpg_n = 0; done_at = -1;
            start = 1'b1;
            sig_in = 8'($urandom);
            tick();
            start = 1'b0;
            for (int j = 0; j <= MP + ML + 4; j++) begin
                if (j > 0) tick();
                o = obs_m(); e = model(j, MP, ML, sv);
                vectors++;
                if (o !== e) begin miscompares++; $display("FAIL run%0d j=%0d got %h exp %h", r, j, o, e); end
                if (o.clr) clr_n++;
                if (o.tpg) tpg_n++;
                if (o.done && done_at < 0) done_at = j;
                sig_in = (j == MP + ML + 1) ? sv : 8'($urandom);
            end
            vectors++;
            if (clr_n != 1 || tpg_n != MP || done_at != MP + ML + 2) begin
                miscompares++;
                $display("FAIL run%0d_timing clr=%0d tpg=%0d done_at=%0d exp 1/%0d/%0d",
                         r, clr_n, tpg_n, done_at, MP, MP + ML + 2);
            end
        end
    endtask

    // start held high: one run only, DONE held, restart after a start drop
    task automatic test_start_held();
        exp_t o, e;
        logic [7:0] sv;
        sv = GOLD;
        start = 1'b1;
        tick();
        for (int j = 0; j <= MP + ML + 25; j++) begin
            if (j > 0) tick();
            o = obs_m(); e = model(j, MP, ML, sv);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL held j=%0d got %h exp %h", j, o, e); end
            sig_in = (j == MP + ML + 1) ? sv : 8'($urandom);
        end
        start = 1'b0;
        tick();
        o = obs_m(); e = model(MP + ML + 30, MP, ML, sv);
        vectors++;
        if (o !== e) begin miscompares++; $display("FAIL held_drop got %h exp %h", o, e); end
        start = 1'b1;
        sv = ($urandom_range(0, 1) == 1) ? GOLD : rnd_bad();
        tick();
        for (int j = 0; j <= MP + ML + 3; j++) begin
            if (j > 0) tick();
            o = obs_m(); e = model(j, MP, ML, sv);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL held_rerun j=%0d got %h exp %h", j, o, e); end
            sig_in = (j == MP + ML + 1) ? sv : 8'($urandom);
        end
        start = 1'b0;
        tick();
    endtask

    // Abort at pat_count=100, abort ignored in DONE, abort at a random point
    task automatic test_abort();
        exp_t o, e;
        logic [7:0] sv;
        int ja;
        sv = GOLD;
        start = 1'b1;
        tick();
        for (int j = 0; j <= 101; j++) begin
            if (j > 0) tick();
            o = obs_m(); e = model(j, MP, ML, sv);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL abort100 j=%0d got %h exp %h", j, o, e); end
            sig_in = 8'($urandom);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        e = '0; e.pc = 16'd100;
        for (int k = 0; k < 10; k++) begin
            o = obs_m(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL abort_idle k=%0d got %h exp %h", k, o, e); end
            tick();
        end
        start = 1'b0;
        tick();
        o = obs_m(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL abort_drop got %h exp %h", o, e); end
        start = 1'b1;
        tick();
        start = 1'b0;
        sv = rnd_bad();
        for (int j = 0; j <= MP + ML + 3; j++) begin
            if (j > 0) tick();
            o = obs_m(); e = model(j, MP, ML, sv);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL abort_rerun j=%0d got %h exp %h", j, o, e); end
            sig_in = (j == MP + ML + 1) ? sv : 8'($urandom);
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        o = obs_m(); e = model(MP + ML + 4, MP, ML, sv);
        vectors++;
        if (o !== e) begin miscompares++; $display("FAIL abort_in_done got %h exp %h", o, e); end
        tick();
        ja = $urandom_range(0, MP + ML + 1);
        sv = GOLD;
        for (int j = 0; j <= ja; j++) begin
            if (j > 0) tick();
            o = obs_m(); e = model(j, MP, ML, sv);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL abort_rnd j=%0d got %h exp %h", j, o, e); end
            sig_in = (j == MP + ML + 1) ? sv : 8'($urandom);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        e = '0; e.pc = model(ja, MP, ML, sv).pc;
        o = obs_m(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL abort_rnd_at=%0d got %h exp %h", ja, o, e); end
        tick();
    endtask

    // Asynchronous reset mid-FLUSH, then a fresh full run
    task automatic test_async_reset();
        exp_t o, e;
        logic [7:0] sv;
        int done_at;
        sv = GOLD;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j <= MP + 1; j++) begin
            if (j > 0) tick();
            o = obs_m(); e = model(j, MP, ML, sv);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL areset_pre j=%0d got %h exp %h", j, o, e); end
            sig_in = 8'($urandom);
        end
        #2 rst_n = 1'b0;
        #1;
        o = obs_m(); vectors++;
        if (o !== exp_t'(0)) begin miscompares++; $display("FAIL areset_now got %h exp 0", o); end
        #2 rst_n = 1'b1;
        tick();
        o = obs_m(); vectors++;
        if (o !== exp_t'(0)) begin miscompares++; $display("FAIL areset_after got %h exp 0", o); end
        start = 1'b1;
        tick();
        start = 1'b0;
        done_at = -1;
        for (int j = 0; j <= MP + ML + 4; j++) begin
            if (j > 0) tick();
            o = obs_m(); e = model(j, MP, ML, sv);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL areset_run j=%0d got %h exp %h", j, o, e); end
            if (o.done && done_at < 0) done_at = j;
            sig_in = (j == MP + ML + 1) ? sv : 8'($urandom);
        end
        vectors++;
        if (done_at != MP + ML + 2) begin
            miscompares++; $display("FAIL areset_latency got %0d exp %0d", done_at, MP + ML + 2);
        end
    endtask

    // PATTERNS=4, CUT_LAT=0 build: no FLUSH, done after 6 cycles
    task automatic test_short();
        exp_t o, e;
        logic [7:0] sv;
        int tpg_n, done_at;
        for (int r = 0; r < 2; r++) begin
            sv = (r == 0) ? GOLD : rnd_bad();
            tpg_n = 0; done_at = -1;
            s_start = 1'b1;
            tick();
            s_start = 1'b0;
            for (int j = 0; j <= 10; j++) begin
                if (j > 0) tick();
                o = obs_s(); e = model(j, SP, SL, sv);
                vectors++;
                if (o !== e) begin miscompares++; $display("FAIL short%0d j=%0d got %h exp %h", r, j, o, e); end
                if (o.tpg) tpg_n++;
                if (o.done && done_at < 0) done_at = j;
                s_sig_in = (j == SP + SL + 1) ? sv : 8'($urandom);
            end
            vectors++;
            if (tpg_n != SP || done_at != SP + SL + 2 || s_pc !== 16'd3) begin
                miscompares++;
                $display("FAIL short%0d_timing tpg=%0d done_at=%0d pc=%0d exp %0d/%0d/3",
                         r, tpg_n, done_at, s_pc, SP, SP + SL + 2);
            end
        end
    endtask

    initial begin
        start = 1'b0; abort = 1'b0; sig_in = '0;
        s_start = 1'b0; s_abort = 1'b0; s_sig_in = '0;
        test_reset();
        test_run();
        test_start_held();
        test_abort();
        test_async_reset();
        test_short();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
